// File: rtl/tdm_demux_if.sv
// Bundle of the serial-link input side and the parallel-frame output side
// of the TDM demultiplexer. The master modport drives beats and consumes
// frames; the slave modport is the demultiplexer itself.
interface tdm_demux_if #(
  parameter int LANES = 2,
  parameter int WIDTH = 8
);
  localparam int LW = $clog2(LANES);

  logic                   in_bit;
  logic                   in_valid;
  logic                   in_sof;
  logic [LANES*WIDTH-1:0] out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [LW-1:0]          lane;
  logic                   sync_err;
  logic                   overflow;

  modport master (
    output in_bit, in_valid, in_sof, out_ready,
    input  out_data, out_valid, lane, sync_err, overflow
  );

  modport slave (
    input  in_bit, in_valid, in_sof, out_ready,
    output out_data, out_valid, lane, sync_err, overflow
  );
endinterface

// File: rtl/tdm_demux.sv
// Time-division demultiplexer. Beats arrive lane-interleaved, LSB first:
// beat k carries bit (k / LANES) of lane (k % LANES). The beat position is
// tracked as a lane counter plus a bit counter so no divider is needed.
// A completed frame is moved into a single output register guarded by a
// valid/ready handshake; a frame that finds that register occupied is
// dropped and flagged on the sticky overflow output.
module tdm_demux #(
  parameter int LANES = 2,
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  tdm_demux_if.slave  bus
);
  localparam int LW = $clog2(LANES);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int FW = LANES * WIDTH;

  typedef enum logic {HUNT = 1'b0, RECV = 1'b1} state_t;

  state_t          state_r;
  logic [LW-1:0]   lane_r;
  logic [BW-1:0]   bit_r;
  logic [FW-1:0]   stage_r;
  logic [FW-1:0]   out_data_r;
  logic            out_valid_r;
  logic            sync_err_r;
  logic            overflow_r;

  logic [FW-1:0]   stage_next_s;
  logic            restart_s;
  logic            last_s;
  logic            out_free_s;

  // A sof beat always lands in slot 0; otherwise the beat goes to the slot
  // addressed by the current lane/bit counters.
  always_comb begin
    stage_next_s = stage_r;
    restart_s    = bus.in_sof || (state_r == HUNT);
    for (int l = 0; l < LANES; l++) begin
      for (int b = 0; b < WIDTH; b++) begin
        if (restart_s) begin
          if (l == 0 && b == 0) begin
            stage_next_s[0] = bus.in_bit;
          end else begin
            stage_next_s[l*WIDTH + b] = stage_r[l*WIDTH + b];
          end
        end else if (lane_r == LW'(l) && bit_r == BW'(b)) begin
          stage_next_s[l*WIDTH + b] = bus.in_bit;
        end else begin
          stage_next_s[l*WIDTH + b] = stage_r[l*WIDTH + b];
        end
      end
    end
  end

  // Last-beat detection and output-register availability.
  always_comb begin
    if (state_r == RECV && bus.in_valid && !bus.in_sof &&
        lane_r == LW'(LANES - 1) && bit_r == BW'(WIDTH - 1)) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
    out_free_s = !out_valid_r || bus.out_ready;
  end

  // Frame FSM, beat counters, staging and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= HUNT;
      lane_r      <= '0;
      bit_r       <= '0;
      stage_r     <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      sync_err_r  <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      sync_err_r <= 1'b0;
      if (out_valid_r && bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
      case (state_r)
        HUNT: begin
          if (bus.in_valid && bus.in_sof) begin
            stage_r <= stage_next_s;
            lane_r  <= LW'(1);
            bit_r   <= '0;
            state_r <= RECV;
          end
        end
        RECV: begin
          if (bus.in_valid) begin
            stage_r <= stage_next_s;
            if (bus.in_sof) begin
              // Mid-frame sof: abandon the partial frame, restart here.
              sync_err_r <= 1'b1;
              lane_r     <= LW'(1);
              bit_r      <= '0;
            end else if (last_s) begin
              state_r <= HUNT;
              lane_r  <= '0;
              bit_r   <= '0;
              if (out_free_s) begin
                out_data_r  <= stage_next_s;
                out_valid_r <= 1'b1;
              end else begin
                overflow_r <= 1'b1;
              end
            end else if (lane_r == LW'(LANES - 1)) begin
              lane_r <= '0;
              bit_r  <= bit_r + BW'(1);
            end else begin
              lane_r <= lane_r + LW'(1);
            end
          end
        end
        default: begin
          state_r <= HUNT;
        end
      endcase
    end
  end

  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.lane      = lane_r;
  assign bus.sync_err  = sync_err_r;
  assign bus.overflow  = overflow_r;
endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (LANES=2, WIDTH=8): a table of frames with
// hand-computed expected words, plus sequences for hunt, resync,
// backpressure/overflow, back-to-back frames and mid-frame reset.
module tb_tdm_demux;
  localparam int LANES = 2;
  localparam int WIDTH = 8;
  localparam int NB    = LANES * WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;

  always #5 clk = ~clk;

  tdm_demux_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

  tdm_demux #(.LANES(LANES), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0]  l0;
    logic [7:0]  l1;
    logic [15:0] gaps;   // bit k set: one idle cycle before beat k
    logic [15:0] exp;    // expected out_data
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // One cycle: drive at negedge, sample 1 time unit after the posedge.
  task automatic step(input logic v, input logic b, input logic s, input logic r);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_bit    = b;
    bus.in_sof    = s;
    bus.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic frame_bit(input logic [15:0] w, input int k);
    return w[(k % LANES) * WIDTH + k / LANES];
  endfunction

  // Full frame; hold >= 0 means an undelivered frame with that data must
  // stay stable on the output throughout.
  task automatic send_frame(input logic [15:0] w, input logic [15:0] gaps,
                            input logic r, input logic first_sync,
                            input logic [15:0] exp_after, input logic exp_ovf,
                            input int hold);
    for (int k = 0; k < NB; k++) begin
      if (gaps[k] && k > 0) begin
        step(1'b0, 1'b0, 1'b0, r);
        chk("idle_lane", bus.lane, k % LANES);
      end
      step(1'b1, frame_bit(w, k), (k == 0), r);
      chk("lane", bus.lane, (k + 1) % LANES);
      chk("sync_err", bus.sync_err, (k == 0) ? first_sync : 1'b0);
      if (k < NB - 1) begin
        if (hold >= 0) begin
          chk("hold_valid", bus.out_valid, 1'b1);
          chk("hold_data", bus.out_data, hold[15:0]);
        end else if (r) begin
          chk("midframe_valid", bus.out_valid, 1'b0);
        end
      end
    end
    chk("done_valid", bus.out_valid, 1'b1);
    chk("done_data", bus.out_data, exp_after);
    chk("done_overflow", bus.overflow, exp_ovf);
  endtask

  task automatic send_partial(input logic [15:0] w, input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b1, frame_bit(w, k), (k == 0), 1'b1);
      chk("partial_valid", bus.out_valid, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.in_sof    = 1'b0;
    bus.out_ready = 1'b0;

    vecs[0] = '{l0: 8'hA5, l1: 8'h3C, gaps: 16'h0000, exp: 16'h3CA5};
    vecs[1] = '{l0: 8'hA5, l1: 8'h3C, gaps: 16'h4A52, exp: 16'h3CA5};
    vecs[2] = '{l0: 8'h12, l1: 8'h34, gaps: 16'h8124, exp: 16'h3412};
    vecs[3] = '{l0: 8'hFF, l1: 8'h00, gaps: 16'h0F00, exp: 16'h00FF};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_data", bus.out_data, 16'h0000);
    chk("rst_lane", bus.lane, 1'b0);
    chk("rst_sync", bus.sync_err, 1'b0);
    chk("rst_ovf", bus.overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven frames, with and without idle gaps.
    for (int i = 0; i < 4; i++) begin
      send_frame({vecs[i].l1, vecs[i].l0}, vecs[i].gaps, 1'b1, 1'b0,
                 vecs[i].exp, 1'b0, -1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("pulse_end", bus.out_valid, 1'b0);
    end

    // Hunt: non-sof beats are discarded.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, i[0], 1'b0, 1'b1);
      chk("hunt_lane", bus.lane, 1'b0);
      chk("hunt_valid", bus.out_valid, 1'b0);
    end
    send_frame(16'hC35A, 16'h0000, 1'b1, 1'b0, 16'hC35A, 1'b0, -1);

    // Resync: sof at beat 6 of a frame.
    send_partial(16'h7E81, 6);
    send_frame(16'hB2E1, 16'h0000, 1'b1, 1'b1, 16'hB2E1, 1'b0, -1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("resync_end", bus.out_valid, 1'b0);

    // Backpressure: first frame held, second dropped.
    send_frame(16'h2211, 16'h0000, 1'b0, 1'b0, 16'h2211, 1'b0, -1);
    send_frame(16'h4433, 16'h0000, 1'b0, 1'b0, 16'h2211, 1'b1, 16'h2211);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_still_valid", bus.out_valid, 1'b1);
    chk("bp_still_data", bus.out_data, 16'h2211);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_delivered", bus.out_valid, 1'b0);
    chk("bp_ovf_sticky", bus.overflow, 1'b1);

    // Three back-to-back frames.
    send_frame(16'h0102, 16'h0000, 1'b1, 1'b0, 16'h0102, 1'b1, -1);
    send_frame(16'hF00F, 16'h0000, 1'b1, 1'b0, 16'hF00F, 1'b1, -1);
    send_frame(16'h5AA5, 16'h0000, 1'b1, 1'b0, 16'h5AA5, 1'b1, -1);

    // Reset mid-frame, beats during reset are ignored.
    send_partial(16'h9999, 7);
    @(negedge clk);
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_sof    = 1'b1;
    bus.in_bit    = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_valid", bus.out_valid, 1'b0);
    chk("mrst_data", bus.out_data, 16'h0000);
    chk("mrst_lane", bus.lane, 1'b0);
    chk("mrst_sync", bus.sync_err, 1'b0);
    chk("mrst_ovf", bus.overflow, 1'b0);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    send_frame(16'h3CA5, 16'h0000, 1'b1, 1'b0, 16'h3CA5, 1'b0, -1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("final_end", bus.out_valid, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: the receiving end of a 2:1/N:1 mux-based serial link. The transmitter's select rotates one lane per beat. This block takes the interleaved single-bit stream, steers each bit back to its lane, and assembles one WIDTH-bit word per lane. It then presents all lanes as one parallel frame on a valid/ready output. It sits between the serial link pins and the parallel consumer logic.

## Interface
- LANES, default 2: number of interleaved lanes; legal range is 2 and up.
- WIDTH, default 8: bits per lane per frame; legal range is 1 and up.

- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_bit  input  1  serial data bit.
- in_valid  input  1  in_bit, in_sof are meaningful this cycle (one beat).
- in_sof  input  1  marks the beat as frame beat 0; qualified by in_valid.
- out_data  output  LANES*WIDTH  assembled frame; lane L occupies bits [L*WIDTH +: WIDTH].
- out_valid  output  1  out_data holds an undelivered frame.
- out_ready  input  1  consumer accepts out_data this cycle when out_valid=1.
- lane  output  $clog2(LANES)  lane that the next accepted beat will be written to.
- sync_err  output  1  one-cycle pulse: in_sof arrived mid-frame.
- overflow  output  1  sticky: a completed frame was dropped.

## Operation
- Beat mapping: frame beat k (k = 0 .. LANES*WIDTH-1) carries bit (k / LANES) of lane (k % LANES). LSB is sent first.
- Beat counter: range 0 .. LANES*WIDTH-1.
  - lane = counter % LANES; bit index = counter / LANES.
  - Implement as a lane counter plus a bit counter, with no divider.
- Staging register: LANES*WIDTH bits. Each accepted beat is written into its slot; other slots hold their value.
- State HUNT (reset state):
  - A beat with in_valid=1 and in_sof=0 is discarded.
  - A beat with in_valid=1 and in_sof=1 is written as beat 0. Counter becomes 1 (or completes the frame if LANES*WIDTH=1 — not possible with the legal ranges). State moves to RECV.
- State RECV:
  - in_valid=1, in_sof=0: write the beat and increment the counter.
  - in_valid=1, in_sof=1, counter≠0: pulse sync_err. Restart the frame with this beat as beat 0 (counter becomes 1). Stay in RECV.
  - in_valid=0: no change.
- Last beat (counter = LANES*WIDTH-1, accepted with in_sof=0):
  - The frame completes and state returns to HUNT.
  - If the output register is free (out_valid=0, or out_valid=1 and out_ready=1 in the same cycle): load the staging register (including this beat) into out_data and set out_valid.
  - Otherwise: drop the frame, set overflow, and leave out_data/out_valid unchanged.
- Output handshake:
  - out_valid=1 and out_ready=1 clears out_valid, unless a new frame loads in the same cycle; then out_valid stays 1 and out_data updates.
  - out_data must not change while out_valid=1 and out_ready=0.
- overflow is cleared only by reset.

## Timing
- Reset (rst_n=0 at a clock edge): state=HUNT, counter=0, lane=0, out_valid=0, out_data=0, sync_err=0, overflow=0, staging register=0. Beats presented during reset are ignored.
- Latency: out_valid and the new out_data are visible the cycle after the last beat is accepted.
- Throughput: one beat per cycle. A back-to-back next frame may start in the cycle directly after the last beat, and its sof beat is accepted in HUNT.
- sync_err is high exactly one cycle, the cycle after the offending beat.
- overflow rises the cycle after the dropped last beat.
- out_ready is ignored while out_valid=0.
- Reset in mid-frame discards the partial frame and any held output.

## Test plan
- LANES=2, WIDTH=8: send a frame with lane0=0xA5, lane1=0x3C, interleaved LSB first (16 beats, sof on beat 0), with out_ready=1. Required: out_data=0x3CA5 and out_valid=1 for one cycle, one cycle after beat 15.
- Idle gaps: insert in_valid=0 at random between beats of the same frame. Required: identical out_data; lane tracks the expected index throughout.
- Hunt: send 5 beats with in_sof=0 first, then a valid frame. Required: the leading beats are discarded and the frame decodes correctly.
- Resync: in_sof at beat 6 of a frame. Required: sync_err pulses once; the frame restarting at that beat decodes correctly; no output is produced for the aborted frame.
- Backpressure: out_ready=0 for two full frames. Required: first frame held stable, second frame dropped, overflow=1. Then out_ready=1: first frame delivered, overflow stays 1.
- Back-to-back and reset: three contiguous frames with out_ready=1 give three out_valid pulses in order. Then rst_n=0 for one cycle mid-frame: all outputs 0, and the next frame decodes correctly.
